// File: rtl/priority_encoder_pkg.sv
// Shared code width and encoded index values for the 4-to-2 priority encoder.
package priority_encoder_pkg;

    localparam int unsigned ENC_W = 2;
    localparam int unsigned N_REQ = 4;

    localparam logic [ENC_W-1:0] IDX0 = ENC_W'(0);
    localparam logic [ENC_W-1:0] IDX1 = ENC_W'(1);
    localparam logic [ENC_W-1:0] IDX2 = ENC_W'(2);
    localparam logic [ENC_W-1:0] IDX3 = ENC_W'(3);

endpackage

// File: rtl/prio_enc_core.sv
// Combinational 4-to-2 priority encode: highest-numbered asserted request wins.
module prio_enc_core
    import priority_encoder_pkg::*;
(
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    output logic [ENC_W-1:0] y,
    output logic             valid
);

    // No request still encodes as IDX0; valid tells it apart from "i0 only".
    always_comb begin
        y     = IDX0;
        valid = i0 | i1 | i2 | i3;
        if (i3) begin
            y = IDX3;
        end else if (i2) begin
            y = IDX2;
        end else if (i1) begin
            y = IDX1;
        end else begin
            y = IDX0;
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// Priority encoder with combinational outputs plus a one-cycle registered copy.
module priority_encoder
    import priority_encoder_pkg::*;
#(
    parameter logic [ENC_W-1:0] RST_Y = IDX0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i0,
    input  logic             i1,
    input  logic             i2,
    input  logic             i3,
    output logic [ENC_W-1:0] y,
    output logic             valid,
    output logic [ENC_W-1:0] y_q,
    output logic             valid_q
);

    logic [ENC_W-1:0] y_d;
    logic             valid_d;

    prio_enc_core u_core (
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .y     (y),
        .valid (valid)
    );

    always_comb begin
        y_d     = y;
        valid_d = valid;
    end

    // Reset acts immediately; combinational outputs are unaffected by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= RST_Y;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder.sv
// Randomized self-checking bench for priority_encoder against a bit-scan reference.
module tb_priority_encoder;

    logic       clk;
    logic       rst;
    logic       i0, i1, i2, i3;
    logic [1:0] y;
    logic       valid;
    logic [1:0] y_q;
    logic       valid_q;

    int n_tests = 0;
    int n_fail  = 0;

    priority_encoder #(.RST_Y(2'b00)) dut (
        .clk     (clk),
        .rst     (rst),
        .i0      (i0),
        .i1      (i1),
        .i2      (i2),
        .i3      (i3),
        .y       (y),
        .valid   (valid),
        .y_q     (y_q),
        .valid_q (valid_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: scan all request bits, the last (highest) set one is the index.
    function automatic logic [2:0] ref_enc(input logic [3:0] r);
        int idx = 0;
        bit any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (r[k]) begin
                idx = k;
                any = 1'b1;
            end
        end
        return {any, 2'(idx)};
    endfunction

    task automatic apply(input logic [3:0] r);
        {i3, i2, i1, i0} = r;
    endtask

    task automatic check_comb(input string tag, input logic [3:0] r);
        logic [2:0] e;
        e = ref_enc(r);
        check({tag, "_y"}, 4'(y), 4'(e[1:0]));
        check({tag, "_valid"}, 4'(valid), 4'(e[2]));
    endtask

    logic [3:0] r;
    logic [3:0] sweep_pat [6];
    logic [2:0] exp_q;

    initial begin
        sweep_pat[0] = 4'b0001;
        sweep_pat[1] = 4'b0010;
        sweep_pat[2] = 4'b0100;
        sweep_pat[3] = 4'b1000;
        sweep_pat[4] = 4'b0110;
        sweep_pat[5] = 4'b1111;

        rst = 1'b0;
        apply(4'b0000);
        #1 rst = 1'b1;
        #1;
        check("rst_y", 4'(y), 4'h0);
        check("rst_valid", 4'(valid), 4'h0);
        check("rst_async_y_q", 4'(y_q), 4'h0);
        check("rst_async_valid_q", 4'(valid_q), 4'h0);

        // Exhaustive sweep with reset held: registered outputs must stay cleared.
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            apply(4'(c));
            #1;
            check_comb("sweep", 4'(c));
            check("sweep_hold_y_q", 4'(y_q), 4'h0);
            check("sweep_hold_valid_q", 4'(valid_q), 4'h0);
        end

        // Fixed-expectation table checks.
        @(negedge clk); apply(4'b0001); #1; check("hot0_y", 4'(y), 4'h0); check("hot0_v", 4'(valid), 4'h1);
        @(negedge clk); apply(4'b0010); #1; check("hot1_y", 4'(y), 4'h1);
        @(negedge clk); apply(4'b0100); #1; check("hot2_y", 4'(y), 4'h2);
        @(negedge clk); apply(4'b1000); #1; check("hot3_y", 4'(y), 4'h3);
        @(negedge clk); apply(4'b0110); #1; check("p0110_y", 4'(y), 4'h2);
        @(negedge clk); apply(4'b1111); #1; check("p1111_y", 4'(y), 4'h3);

        // Release reset; registered path has one cycle of latency.
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0101);
        #1;
        check("reg_comb_y", 4'(y), 4'h2);
        check("reg_same_cycle_y_q", 4'(y_q), 4'h0);
        check("reg_same_cycle_valid_q", 4'(valid_q), 4'h0);
        @(posedge clk); #1;
        check("reg_y_q", 4'(y_q), 4'h2);
        check("reg_valid_q", 4'(valid_q), 4'h1);
        exp_q = ref_enc(4'b0101);

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            apply(sweep_pat[k]);
            #1;
            check_comb("table", sweep_pat[k]);
        end
        @(posedge clk); #1;
        exp_q = ref_enc(sweep_pat[5]);

        // Random stimulus: registered outputs lag the combinational ones by one edge.
        repeat (300) begin
            @(negedge clk);
            r = 4'($urandom_range(0, 15));
            apply(r);
            #1;
            check_comb("rand", r);
            check("rand_hold_y_q", 4'(y_q), 4'(exp_q[1:0]));
            check("rand_hold_valid_q", 4'(valid_q), 4'(exp_q[2]));
            @(posedge clk); #1;
            exp_q = ref_enc(r);
            check("rand_y_q", 4'(y_q), 4'(exp_q[1:0]));
            check("rand_valid_q", 4'(valid_q), 4'(exp_q[2]));
        end

        // Mid-operation asynchronous reset between edges.
        @(negedge clk);
        apply(4'b1000);
        @(posedge clk); #1;
        check("mid_pre_y_q", 4'(y_q), 4'h3);
        check("mid_pre_valid_q", 4'(valid_q), 4'h1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_y_q", 4'(y_q), 4'h0);
        check("mid_rst_valid_q", 4'(valid_q), 4'h0);
        check("mid_rst_y", 4'(y), 4'h3);
        check("mid_rst_valid", 4'(valid), 4'h1);
        @(posedge clk); #1;
        check("mid_hold_y_q", 4'(y_q), 4'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(4'b0010);
        #1;
        check("rel_no_edge_y_q", 4'(y_q), 4'h0);
        @(posedge clk); #1;
        check("rel_y_q", 4'(y_q), 4'h1);
        check("rel_valid_q", 4'(valid_q), 4'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
